// File: rtl/norm_left_shifter_pkg.sv
// Shared widths, constants and helpers for the floating-point adder datapath.
// The normalization stage and the alignment stage both build on these.
package norm_left_shifter_pkg;

  localparam int MANT_W  = 32;
  localparam int EXP_W   = 8;
  localparam int SHIFT_W = 6;

  localparam logic [SHIFT_W-1:0] LZC_ZERO = SHIFT_W'(MANT_W);

  typedef struct packed {
    logic [MANT_W-1:0]  mant;
    logic [EXP_W-1:0]   exp;
    logic               sign;
    logic [SHIFT_W-1:0] lzc;
  } stage_a_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic              sign;
    logic              zero;
    logic              underflow;
  } result_t;

  // Leading-zero count; an all-zero word reports LZC_ZERO.
  function automatic logic [SHIFT_W-1:0] count_lz(input logic [MANT_W-1:0] value);
    logic [SHIFT_W-1:0] count;
    logic               found;
    count = LZC_ZERO;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = SHIFT_W'(MANT_W - 1 - i);
        found = 1'b1;
      end
    end
    return count;
  endfunction

endpackage

// File: rtl/norm_left_shifter_if.sv
// Input and output valid/ready channels of the normalization stage.
// The master side feeds mantissas in and drains results; the slave side is the stage.
interface norm_left_shifter_if;
  import norm_left_shifter_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              in_sign;

  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_sign;
  logic              out_zero;
  logic              out_underflow;

  modport master (
    output in_valid, in_mant, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_underflow
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_underflow
  );

endinterface

// File: rtl/norm_left_shifter_shifter.sv
// Combinational left barrel shifter built from a chain of 2:1 mux layers.
// Layer k moves the word by 2**k; the top layer (32) empties the word entirely.
module mux_2x1 #(
  parameter int W = 32
) (
  output logic [W-1:0] out,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel
);

  assign out = sel ? b : a;

endmodule

module thirty_two_bit_left_shifter
  import norm_left_shifter_pkg::*;
(
  output logic [MANT_W-1:0]  out,
  input  logic [MANT_W-1:0]  a,
  input  logic [SHIFT_W-1:0] shift
);

  logic [MANT_W-1:0] stage [SHIFT_W+1];

  assign stage[0] = a;

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_layer
    logic [MANT_W-1:0] moved;

    // A distance at or beyond the word width leaves nothing but zero fill.
    if ((1 << k) < MANT_W) begin : g_shift
      assign moved = stage[k] << (1 << k);
    end else begin : g_flush
      assign moved = '0;
    end

    mux_2x1 #(.W(MANT_W)) u_mux (
      .out (stage[k+1]),
      .a   (stage[k]),
      .b   (moved),
      .sel (shift[k])
    );
  end

  assign out = stage[SHIFT_W];

endmodule

// File: rtl/norm_left_shifter.sv
// Two-stage normalization after the mantissa add: count leading zeros, then
// shift the mantissa up and pull the exponent down, flushing to zero on underflow.
module norm_left_shifter
  import norm_left_shifter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  norm_left_shifter_if.slave  bus
);

  stage_a_t          a_q;
  stage_a_t          a_next;
  logic              a_valid;

  result_t           b_q;
  result_t           b_next;
  logic              b_valid;
  logic              b_advance;

  logic [MANT_W-1:0] shifted;
  logic [EXP_W-1:0]  lzc_ext;

  // Both stages move together; a full stage A may still accept when B drains.
  assign b_advance    = !b_valid || bus.out_ready;
  assign bus.in_ready = !a_valid || b_advance;

  always_comb begin
    a_next      = '0;
    a_next.mant = bus.in_mant;
    a_next.exp  = bus.in_exp;
    a_next.sign = bus.in_sign;
    a_next.lzc  = count_lz(bus.in_mant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else if (bus.in_ready) begin
      a_valid <= bus.in_valid;
      if (bus.in_valid) begin
        a_q <= a_next;
      end
    end
  end

  thirty_two_bit_left_shifter u_shifter (
    .out   (shifted),
    .a     (a_q.mant),
    .shift (a_q.lzc)
  );

  assign lzc_ext = EXP_W'(a_q.lzc);

  // Zero and underflow both collapse to an all-zero result; only the flag differs.
  always_comb begin
    b_next           = '0;
    b_next.sign      = a_q.sign;
    if (a_q.mant == '0) begin
      b_next.zero      = 1'b1;
    end else if (a_q.exp <= lzc_ext) begin
      b_next.zero      = 1'b1;
      b_next.underflow = 1'b1;
    end else begin
      b_next.mant      = shifted;
      b_next.exp       = a_q.exp - lzc_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_q     <= '0;
    end else if (b_advance) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_q <= b_next;
      end
    end
  end

  assign bus.out_valid     = b_valid;
  assign bus.out_mant      = b_q.mant;
  assign bus.out_exp       = b_q.exp;
  assign bus.out_sign      = b_q.sign;
  assign bus.out_zero      = b_q.zero;
  assign bus.out_underflow = b_q.underflow;

endmodule
